// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses PLL areset, qualifies a synchronized lock over a
// stability window, then releases the CPU reset and strobes a divided clock enable.
module pll_lock_sequencer #(
  parameter int unsigned ARESET_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1000,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CLK_EN_DIV    = 4,
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  output logic               pll_areset,
  output logic               sys_rst_n,
  output logic               clk_en_sys,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  localparam int unsigned AR_W  = (ARESET_CYCLES > 1) ? $clog2(ARESET_CYCLES) : 1;
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT);
  localparam int unsigned ST_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned DIV_W = (CLK_EN_DIV > 1) ? $clog2(CLK_EN_DIV) : 1;

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic [1:0]         lock_sync;
  logic               lock_s;
  logic [2:0]         state_nxt;
  logic [AR_W-1:0]    ar_cnt, ar_cnt_nxt;
  logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
  logic [ST_W-1:0]    st_cnt, st_cnt_nxt;
  logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               pll_areset_nxt, sys_rst_n_nxt, clk_en_nxt, ready_nxt, fault_nxt;

  assign lock_s = lock_sync[1];

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync <= 2'b00;
    else        lock_sync <= {lock_sync[0], pll_locked};
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PLL_RST;
      ar_cnt     <= '0;
      to_cnt     <= '0;
      st_cnt     <= '0;
      div_cnt    <= '0;
      retry_cnt  <= '0;
      pll_areset <= 1'b1;
      sys_rst_n  <= 1'b0;
      clk_en_sys <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      ar_cnt     <= ar_cnt_nxt;
      to_cnt     <= to_cnt_nxt;
      st_cnt     <= st_cnt_nxt;
      div_cnt    <= div_cnt_nxt;
      retry_cnt  <= retry_nxt;
      pll_areset <= pll_areset_nxt;
      sys_rst_n  <= sys_rst_n_nxt;
      clk_en_sys <= clk_en_nxt;
      ready      <= ready_nxt;
      fault      <= fault_nxt;
    end
  end

  // Next-state and counter logic; each counter is cleared on entry to the state that uses it
  always_comb begin
    state_nxt   = state;
    ar_cnt_nxt  = ar_cnt;
    to_cnt_nxt  = to_cnt;
    st_cnt_nxt  = st_cnt;
    div_cnt_nxt = div_cnt;
    retry_nxt   = retry_cnt;
    case (state)
      S_PLL_RST: begin
        if (ar_cnt == AR_W'(ARESET_CYCLES - 1)) begin
          state_nxt  = S_WAIT_LOCK;
          to_cnt_nxt = '0;
          ar_cnt_nxt = '0;
        end else begin
          ar_cnt_nxt = ar_cnt + AR_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle wins over the retry
        if (lock_s) begin
          state_nxt  = S_STABILIZE;
          st_cnt_nxt = '0;
        end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
          if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
            state_nxt = S_FAULT;
          end else begin
            state_nxt  = S_PLL_RST;
            retry_nxt  = retry_cnt + RETRY_W'(1);
            ar_cnt_nxt = '0;
          end
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      S_STABILIZE: begin
        if (!lock_s) begin
          state_nxt  = S_WAIT_LOCK;
          to_cnt_nxt = '0;
        end else if (st_cnt == ST_W'(STABLE_CYCLES - 1)) begin
          state_nxt   = S_RUN;
          div_cnt_nxt = '0;
        end else begin
          st_cnt_nxt = st_cnt + ST_W'(1);
        end
      end
      S_RUN: begin
        // Lock loss restarts the whole sequence with a fresh retry budget
        if (!lock_s) begin
          state_nxt  = S_PLL_RST;
          retry_nxt  = '0;
          ar_cnt_nxt = '0;
        end else if (div_cnt == DIV_W'(CLK_EN_DIV - 1)) begin
          div_cnt_nxt = '0;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_PLL_RST;
    endcase
  end

  // Output values follow the state being entered so they change on the same edge
  always_comb begin
    pll_areset_nxt = (state_nxt == S_PLL_RST) || (state_nxt == S_FAULT);
    sys_rst_n_nxt  = (state_nxt == S_RUN);
    ready_nxt      = (state_nxt == S_RUN);
    fault_nxt      = (state_nxt == S_FAULT);
    clk_en_nxt     = (state_nxt == S_RUN) && (div_cnt_nxt == DIV_W'(CLK_EN_DIV - 1));
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: a default instance and a CLK_EN_DIV=1,
// MAX_RETRY=0 instance, checked against a queue of expected results.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, pll_locked;
  logic       pll_areset, sys_rst_n, clk_en_sys, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  logic       rst2_n, lock2;
  logic       areset2, sys2_n, en2, ready2, fault2;
  logic [0:0] retry2;
  logic [2:0] state2;

  int checks = 0;
  int errors = 0;
  int n;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pll_lock_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .pll_areset(pll_areset), .sys_rst_n(sys_rst_n), .clk_en_sys(clk_en_sys),
    .ready(ready), .fault(fault), .retry_cnt(retry_cnt), .state(state)
  );

  pll_lock_sequencer #(
    .ARESET_CYCLES(2), .LOCK_TIMEOUT(20), .STABLE_CYCLES(4),
    .MAX_RETRY(0), .CLK_EN_DIV(1)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .pll_locked(lock2),
    .pll_areset(areset2), .sys_rst_n(sys2_n), .clk_en_sys(en2),
    .ready(ready2), .fault(fault2), .retry_cnt(retry2), .state(state2)
  );

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %0d expected <queued value>", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_check(obs);
  endtask

  function automatic bit pred(input int sel, input logic [31:0] arg);
    case (sel)
      0: return 32'(state) == arg;
      1: return 32'(pll_areset) == arg;
      2: return 32'(sys_rst_n) == arg;
      3: return 32'(state) != arg;
      4: return 32'(state2) == arg;
      5: return 32'(state2) != arg;
      default: return 1'b0;
    endcase
  endfunction

  // Negedges until the predicate holds, capped at budget
  task automatic count_edges(input int sel, input logic [31:0] arg, input int budget, output int cnt);
    cnt = 0;
    while (!pred(sel, arg) && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_for(input string tag, input int sel, input logic [31:0] arg, input int budget);
    int c;
    sb_push(tag, 32'd1);
    count_edges(sel, arg, budget, c);
    sb_check(32'(pred(sel, arg)));
  endtask

  task automatic check_reset_vals(input string tag);
    expect_now({tag, "_state"},  32'(state), 32'd0);
    expect_now({tag, "_areset"}, 32'(pll_areset), 32'd1);
    expect_now({tag, "_sysrst"}, 32'(sys_rst_n), 32'd0);
    expect_now({tag, "_clken"},  32'(clk_en_sys), 32'd0);
    expect_now({tag, "_ready"},  32'(ready), 32'd0);
    expect_now({tag, "_fault"},  32'(fault), 32'd0);
    expect_now({tag, "_retry"},  32'(retry_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0;
    rst2_n = 1'b0; lock2 = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");

    // Bring-up with lock arriving 20 cycles after areset falls
    rst_n = 1'b1;
    sb_push("t1_areset_edges", 32'd8);
    count_edges(1, 32'd0, 50, n);
    sb_check(32'(n));
    expect_now("t1_wait_state", 32'(state), 32'd1);
    repeat (19) @(negedge clk);
    expect_now("t1_wait_retry", 32'(retry_cnt), 32'd0);
    pll_locked = 1'b1;
    // two synchronizer flops plus the state register
    sb_push("t1_lock_to_stab", 32'd3);
    count_edges(0, 32'd2, 20, n);
    sb_check(32'(n));
    sb_push("t1_stab_window", 32'd64);
    count_edges(2, 32'd1, 200, n);
    sb_check(32'(n));
    expect_now("t1_ready", 32'(ready), 32'd1);
    expect_now("t1_run_state", 32'(state), 32'd3);
    expect_now("t1_run_areset", 32'(pll_areset), 32'd0);

    // Divided enable in RUN, then lock loss
    for (int i = 0; i < 8; i++) begin
      expect_now("t4_clken", 32'(clk_en_sys), 32'((i % 4) == 3));
      @(negedge clk);
    end
    pll_locked = 1'b0;
    @(negedge clk);
    expect_now("t4_sysrst_e1", 32'(sys_rst_n), 32'd1);
    @(negedge clk);
    expect_now("t4_sysrst_e2", 32'(sys_rst_n), 32'd1);
    @(negedge clk);
    expect_now("t4_sysrst_e3", 32'(sys_rst_n), 32'd0);
    expect_now("t4_clken_e3",  32'(clk_en_sys), 32'd0);
    expect_now("t4_areset_e3", 32'(pll_areset), 32'd1);
    expect_now("t4_ready_e3",  32'(ready), 32'd0);
    expect_now("t4_state_e3",  32'(state), 32'd0);
    expect_now("t4_retry_e3",  32'(retry_cnt), 32'd0);

    // One-cycle lock dropout during STABILIZE
    pll_locked = 1'b1;
    wait_for("t2_reach_stab", 0, 32'd2, 30);
    repeat (29) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_for("t2_back_to_wait", 0, 32'd1, 10);
    expect_now("t2_retry", 32'(retry_cnt), 32'd0);
    expect_now("t2_sysrst_low", 32'(sys_rst_n), 32'd0);
    wait_for("t2_restab", 0, 32'd2, 10);
    sb_push("t2_full_window", 32'd64);
    count_edges(2, 32'd1, 200, n);
    sb_check(32'(n));
    expect_now("t2_retry_run", 32'(retry_cnt), 32'd0);

    // Asynchronous reset in the middle of STABILIZE
    pll_locked = 1'b0;
    wait_for("t5_to_pll_rst", 0, 32'd0, 10);
    pll_locked = 1'b1;
    wait_for("t5_reach_stab", 0, 32'd2, 30);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    sb_push("t5_areset_edges", 32'd8);
    count_edges(1, 32'd0, 50, n);
    sb_check(32'(n));
    expect_now("t5_wait_state", 32'(state), 32'd1);
    wait_for("t5_restab", 0, 32'd2, 10);

    // No lock: retries exhaust into FAULT
    pll_locked = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_for("t3_enter_wait", 0, 32'd1, 20);
      expect_now("t3_retry_wait", 32'(retry_cnt), 32'(r));
      sb_push("t3_timeout", 32'd1000);
      count_edges(3, 32'd1, 1100, n);
      sb_check(32'(n));
      if (r < 3) begin
        expect_now("t3_retry_state", 32'(state), 32'd0);
        expect_now("t3_retry_inc", 32'(retry_cnt), 32'(r + 1));
        expect_now("t3_retry_areset", 32'(pll_areset), 32'd1);
      end else begin
        expect_now("t3_fault_state", 32'(state), 32'd4);
        expect_now("t3_fault", 32'(fault), 32'd1);
        expect_now("t3_fault_areset", 32'(pll_areset), 32'd1);
        expect_now("t3_fault_sysrst", 32'(sys_rst_n), 32'd0);
      end
    end
    pll_locked = 1'b1;
    repeat (20) @(negedge clk);
    expect_now("t3_sticky_state", 32'(state), 32'd4);
    expect_now("t3_sticky_fault", 32'(fault), 32'd1);
    expect_now("t3_sticky_areset", 32'(pll_areset), 32'd1);
    expect_now("t3_sticky_ready", 32'(ready), 32'd0);
    expect_now("t3_sticky_retry", 32'(retry_cnt), 32'd3);

    // CLK_EN_DIV=1 and MAX_RETRY=0 instance
    lock2 = 1'b1;
    rst2_n = 1'b1;
    wait_for("t6_reach_run", 4, 32'd3, 50);
    for (int i = 0; i < 10; i++) begin
      expect_now("t6_clken_const", 32'(en2), 32'd1);
      @(negedge clk);
    end
    expect_now("t6_ready", 32'(ready2), 32'd1);
    lock2 = 1'b0;
    wait_for("t6_to_pll_rst", 4, 32'd0, 10);
    wait_for("t6_to_wait", 4, 32'd1, 10);
    sb_push("t6_timeout", 32'd20);
    count_edges(5, 32'd1, 40, n);
    sb_check(32'(n));
    expect_now("t6_fault_state", 32'(state2), 32'd4);
    expect_now("t6_fault", 32'(fault2), 32'd1);
    expect_now("t6_retry", 32'(retry2), 32'd0);
    expect_now("t6_clken_off", 32'(en2), 32'd0);
    expect_now("t6_areset", 32'(areset2), 32'd1);

    expect_now("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
